mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised iterative multiply/divide unit beside the single-cycle integer ALU in the execute stage. It handles the LoongArch MUL/MULH/MULHU/DIV/MOD/DIVU/MODU class on a valid/ready handshake with a fixed, op-dependent latency. A tag is carried through so the issue logic can match each result to its destination. A flush cancels the operation in flight.

## Interface
Parameters:
- WIDTH, 32: operand and result width; even, ≥ 4
- TAG_W, 5: width of the pass-through tag

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous cancel of any in-flight or pending operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  3  operation code (mdu_op_t)
- in_a  in  WIDTH  dividend / multiplicand
- in_b  in  WIDTH  divisor / multiplier
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  WIDTH  result
- out_tag  out  TAG_W  tag captured with the request
- out_divzero  out  1  divide op had divisor 0; always 0 for multiply ops

## Operation
- Op codes:
  - MUL=000: low WIDTH bits of the product
  - MULH=001: high half of the signed product
  - MULHU=010: high half of the unsigned product
  - DIV=100, MOD=101: signed quotient / remainder
  - DIVU=110, MODU=111: unsigned quotient / remainder
  - 011: treated as MUL
- Acceptance: a request is accepted on an edge where in_valid & in_ready & !flush. Operands, op and tag are captured at that edge.
- States:
  - IDLE: in_ready=1. On acceptance go to CALC with counter=WIDTH-1.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, on magnitudes. When counter==0, take the final step and go to FIX.
  - FIX: apply sign correction and special cases, register the result, go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE.
- Signed ops take absolute values at capture and negate the result in FIX:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - Quotient = all ones; remainder = in_a; out_divzero=1.
  - Full latency still applies.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0, out_divzero=0.
- Flush, in any state:
  - Next edge goes to IDLE, out_valid=0, result discarded.
  - Flush wins over a simultaneous in_valid (no acceptance) and over a simultaneous out_ready.
- A single operation is in flight at a time; there is no back-to-back overlap.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, out_divzero=0.
- Latency, measured as out_valid rising after the acceptance edge E0:
  - Divide ops, and multiply ops without the fast path: high after edge E0+WIDTH+1 (WIDTH+1 cycles).
- in_ready is combinational from state (IDLE only). It is not gated by flush; the acceptance rule above already excludes flush.
- out_result, out_tag and out_divzero are registered and held stable while out_valid=1 and out_ready=0.
- The next request can be accepted, at the earliest, in the cycle after the result handshake.
- Reset asserted mid-operation: outputs reach their reset values immediately. No result is produced.

## Configuration
- MDU_FAST_MUL_EN:
  - Defined: multiply ops skip CALC and go IDLE→FIX. The product is computed with a single WIDTH×WIDTH multiplier in FIX. out_valid rises after E0+1 (latency 1).
  - Undefined: multiply ops are iterative, taking WIDTH+1 cycles, with no hardware multiplier inferred.
  - Divide latency is unchanged either way.

## Structure
- Package mdu_pkg holds:
  - mdu_op_t (3-bit enum, codes above)
  - state enum {IDLE, CALC, FIX, DONE}
  - helpers is_div(op), is_signed(op), wants_high(op)
- Sub-module mdu_iter_core:
  - 2·WIDTH shift register plus adder/subtractor
  - performs one multiply or divide step per enable
  - instantiated once
- FSM, sign handling and special cases stay in mdu_iter.

## Test plan
- WIDTH=32, in_a=0xFFFFFFFF, in_b=0x00000002:
  - MUL → 0xFFFFFFFE
  - MULH → 0xFFFFFFFF
  - MULHU → 0x00000001
  - out_divzero=0 for all three
- DIV in_a=-7 (0xFFFFFFF9), in_b=2:
  - result 0xFFFFFFFD; MOD → 0xFFFFFFFF
  - out_valid rises exactly 33 cycles after acceptance
  - out_tag equals in_tag
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, MOD → 0, out_divzero=0.
- DIVU 7/0 → 0xFFFFFFFF, out_divzero=1; MODU 7/0 → 0x00000007.
- Backpressure:
  - Hold out_ready=0 for 5 cycles: result and tag stay stable, in_ready=0.
  - Raise out_ready: next cycle in_ready=1.
  - A new request issued then completes correctly.
- Flush and reset:
  - Flush at CALC cycle 10: out_valid never rises, in_ready=1 next cycle.
  - Flush together with in_valid: request not accepted.
  - resetn low mid-CALC: all outputs at reset values immediately.
  - With MDU_FAST_MUL_EN defined: MUL latency is 1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL     = 3'b000,
    OP_MULH    = 3'b001,
    OP_MULHU   = 3'b010,
    OP_MUL_ALT = 3'b011,
    OP_DIV     = 3'b100,
    OP_MOD     = 3'b101,
    OP_DIVU    = 3'b110,
    OP_MODU    = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op[2];
  endfunction

  // MUL keeps only the low half, which is identical signed or unsigned.
  function automatic logic is_signed(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

  // High register half holds the upper product or the remainder.
  function automatic logic wants_high(input mdu_op_t op);
    return (op == OP_MULH) || (op == OP_MULHU) || (op == OP_MOD) || (op == OP_MODU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Datapath of the unit: a 2*WIDTH shift register doing one shift-add multiply
// or restoring shift-subtract divide step per enable, on unsigned magnitudes.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             en,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic [W:0]   div_diff;

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    mul_sum  = {1'b0, hi_q} + ({1'b0, m} & {(W+1){lo_q[0]}});
    div_sh   = {hi_q, lo_q[W-1]};
    div_diff = div_sh - {1'b0, m};
    if (load) begin
      hi_d = '0;
      lo_d = load_lo;
    end else if (en) begin
      if (div_mode) begin
        // Partial remainder is always below the divisor, so W+1 bits suffice.
        hi_d = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
        lo_d = {lo_q[W-2:0], ~div_diff[W]};
      end else begin
        hi_d = mul_sum[W:1];
        lo_d = {mul_sum[0], lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with valid/ready handshake, tag pass-through and flush.
// Define MDU_FAST_MUL_EN for single-multiplier, 1-cycle multiply ops.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_divzero
);

  localparam int unsigned W     = WIDTH;
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_t          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     a_mag_q, a_mag_d;
  logic [W-1:0]     b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic             aneg_q, aneg_d;
  logic             dz_q, dz_d;
  logic [W-1:0]     result_q, result_d;
  logic             divzero_q, divzero_d;
  logic             out_valid_q, out_valid_d;

  mdu_op_t      op_in;
  logic         in_a_neg, in_b_neg, accept;
  logic [W-1:0] in_a_mag, in_b_mag;
  logic         core_load, core_en, core_div;
  logic [W-1:0] core_load_lo, core_m, core_hi, core_lo;
  logic [W2-1:0] prod_abs, prod_sgn;
  logic [W-1:0]  quo_sgn, rem_sgn;

  assign op_in    = mdu_op_t'(in_op);
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign in_a_neg = is_signed(op_in) & in_a[W-1];
  assign in_b_neg = is_signed(op_in) & in_b[W-1];
  assign in_a_mag = in_a_neg ? (~in_a) + W'(1) : in_a;
  assign in_b_mag = in_b_neg ? (~in_b) + W'(1) : in_b;

  assign core_div     = is_div(op_q);
  assign core_load_lo = is_div(op_in) ? in_a_mag : in_b_mag;
  assign core_m       = core_div ? b_mag_q : a_mag_q;

  mdu_iter_core #(.WIDTH(W)) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .load     (core_load),
    .en       (core_en),
    .div_mode (core_div),
    .load_lo  (core_load_lo),
    .m        (core_m),
    .hi       (core_hi),
    .lo       (core_lo)
  );

`ifdef MDU_FAST_MUL_EN
  assign prod_abs = core_div ? {core_hi, core_lo} : W2'(a_mag_q) * W2'(b_mag_q);
`else
  assign prod_abs = {core_hi, core_lo};
`endif
  assign prod_sgn = neg_q ? (~prod_abs) + W2'(1) : prod_abs;
  assign quo_sgn  = neg_q ? (~core_lo) + W'(1) : core_lo;
  assign rem_sgn  = aneg_q ? (~core_hi) + W'(1) : core_hi;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tag_d       = tag_q;
    a_d         = a_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    neg_d       = neg_q;
    aneg_d      = aneg_q;
    dz_d        = dz_q;
    result_d    = result_q;
    divzero_d   = divzero_q;
    out_valid_d = out_valid_q;
    core_load   = 1'b0;
    core_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = op_in;
          tag_d     = in_tag;
          a_d       = in_a;
          a_mag_d   = in_a_mag;
          b_mag_d   = in_b_mag;
          neg_d     = in_a_neg ^ in_b_neg;
          aneg_d    = in_a_neg;
          dz_d      = (in_b == '0);
          cnt_d     = CNT_W'(WIDTH - 1);
          core_load = 1'b1;
          state_d   = (FAST_MUL && !is_div(op_in)) ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        core_en = 1'b1;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        // MIN / -1 needs no special case: the negated magnitude wraps back to MIN.
        if (core_div) begin
          if (dz_q)                 result_d = wants_high(op_q) ? a_q : '1;
          else if (wants_high(op_q)) result_d = rem_sgn;
          else                      result_d = quo_sgn;
        end else begin
          result_d = wants_high(op_q) ? prod_sgn[W2-1:W] : prod_sgn[W-1:0];
        end
        divzero_d   = core_div & dz_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      divzero_d   = divzero_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MUL;
      tag_q       <= '0;
      a_q         <= '0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      neg_q       <= 1'b0;
      aneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      result_q    <= '0;
      divzero_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tag_q       <= tag_d;
      a_q         <= a_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      neg_q       <= neg_d;
      aneg_q      <= aneg_d;
      dz_q        <= dz_d;
      result_q    <= result_d;
      divzero_q   <= divzero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign out_tag     = tag_q;
  assign out_divzero = divzero_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter at WIDTH=32; honours MDU_FAST_MUL_EN for multiply latency.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int DIV_LAT = 33;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int TIMEOUT = 100;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        dz;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'b000;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_divzero;

  int n_cmp = 0;
  int n_fail = 0;

  mdu_iter #(.WIDTH(32), .TAG_W(5)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_divzero (out_divzero)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // lat counts edges after the acceptance edge until out_valid is seen high.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res, output logic dz,
                        output logic [4:0] tg, output int lat);
    issue(op, a, b, tag);
    wait_valid(lat);
    res = out_result; dz = out_divzero; tg = out_tag;
    handshake();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({out_result, out_tag, out_divzero} !== 38'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h/%b want 0/0/0", out_result, out_tag, out_divzero);
    end
    @(posedge clk); #1; resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input vec_t v[], input int exp_lat);
    logic [31:0] res; logic dz; logic [4:0] tg; int lat;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 3), res, dz, tg, lat);
      n_cmp++; if (res !== v[i].exp) begin n_fail++; $display("FAIL %s_result[%0d]: got %h want %h", name, i, res, v[i].exp); end
      n_cmp++; if (dz !== v[i].dz) begin n_fail++; $display("FAIL %s_divzero[%0d]: got %b want %b", name, i, dz, v[i].dz); end
      n_cmp++; if (tg !== 5'(i + 3)) begin n_fail++; $display("FAIL %s_tag[%0d]: got %h want %h", name, i, tg, 5'(i + 3)); end
      n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, lat, exp_lat); end
    end
  endtask

  task automatic test_mul();
    vec_t v[];
    v = new[6];
    v[0] = '{3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 1'b0};
    v[1] = '{3'b001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1'b0};
    v[2] = '{3'b010, 32'hFFFFFFFF, 32'h2, 32'h00000001, 1'b0};
    v[3] = '{3'b011, 32'h3,        32'h5, 32'h0000000F, 1'b0};
    v[4] = '{3'b000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFF1, 1'b0};
    v[5] = '{3'b010, 32'h80000000, 32'h4, 32'h00000002, 1'b0};
    run_table("mul", v, MUL_LAT);
  endtask

  task automatic test_div();
    vec_t v[];
    v = new[7];
    v[0] = '{3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0};
    v[1] = '{3'b101, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0};
    v[2] = '{3'b100, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    v[3] = '{3'b101, 32'h7,        32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[4] = '{3'b110, 32'd100,      32'd7,        32'd14,       1'b0};
    v[5] = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0};
    v[6] = '{3'b110, 32'hFFFFFFFF, 32'h2,        32'h7FFFFFFF, 1'b0};
    run_table("div", v, DIV_LAT);
  endtask

  task automatic test_boundary();
    vec_t v[];
    v = new[6];
    v[0] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0};
    v[1] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    v[2] = '{3'b110, 32'h7,        32'h0,        32'hFFFFFFFF, 1'b1};
    v[3] = '{3'b111, 32'h7,        32'h0,        32'h00000007, 1'b1};
    v[4] = '{3'b100, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFFF, 1'b1};
    v[5] = '{3'b101, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 1'b1};
    run_table("edge", v, DIV_LAT);
  endtask

  task automatic test_backpressure();
    logic [31:0] res; logic dz; logic [4:0] tg; int lat;
    issue(3'b110, 32'd1000, 32'd9, 5'h1B);
    wait_valid(lat);
    n_cmp++; if (lat !== DIV_LAT) begin n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, DIV_LAT); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({out_valid, in_ready, out_result, out_tag} !== {1'b1, 1'b0, 32'd111, 5'h1B}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b r=%b %h/%h want v=1 r=0 0000006f/1b", i, out_valid, in_ready, out_result, out_tag);
      end
    end
    handshake();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    run_op(3'b111, 32'd1000, 32'd9, 5'h04, res, dz, tg, lat);
    n_cmp++; if ({res, tg, dz} !== {32'd1, 5'h04, 1'b0}) begin n_fail++; $display("FAIL bp_next: got %h/%h/%b want 00000001/04/0", res, tg, dz); end
  endtask

  task automatic test_flush();
    int seen;
    // Flush during CALC.
    issue(3'b100, 32'd50, 32'd5, 5'h11);
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_calc: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_calc_no_result: got %0d valid cycles want 0", seen); end
    // Flush with simultaneous request.
    in_op = 3'b110; in_a = 32'd9; in_b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL flush_accept_no_result: got %0d valid cycles want 0", seen); end
    // Flush while the result waits in DONE.
    issue(3'b110, 32'd9, 32'd3, 5'h02);
    wait_valid(seen);
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL flush_done: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic dz; logic [4:0] tg; int lat;
    run_op(3'b111, 32'd10, 32'd0, 5'h1F, res, dz, tg, lat);
    issue(3'b100, 32'd77, 32'd7, 5'h0A);
    repeat (5) @(posedge clk);
    #3; resetn = 1'b0;
    #1;
    n_cmp++; if ({in_ready, out_valid, out_result, out_tag, out_divzero} !== {2'b10, 38'h0}) begin
      n_fail++; $display("FAIL reset_mid: got r=%b v=%b %h/%h/%b want 1/0/0/0/0", in_ready, out_valid, out_result, out_tag, out_divzero);
    end
    @(posedge clk); #1; resetn = 1'b1;
    lat = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) lat++; end
    n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL reset_mid_no_result: got %0d valid cycles want 0", lat); end
    run_op(3'b100, 32'd77, 32'd7, 5'h0A, res, dz, tg, lat);
    n_cmp++; if ({res, tg} !== {32'd11, 5'h0A}) begin n_fail++; $display("FAIL reset_mid_recover: got %h/%h want 0000000b/0a", res, tg); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_boundary();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
